// File: rtl/riscv_dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its scrubber.
// Polarity constants keep the active-low strobes readable at their use sites.
package riscv_dmem_responder_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int   BYTE_W    = 8;
  localparam int   LANES     = 4;
  localparam int   DATA_W    = BYTE_W * LANES;
  localparam int   ADDR_W    = 12;
  localparam logic WEN_WRITE = 1'b0;
  localparam logic CSN_SEL   = 1'b0;

endpackage

// File: rtl/riscv_dmem_responder_dmem_scrubber.sv
// Walks a pointer over every word after reset so the top can zero the array,
// then hands the array over to the core and raises READY.
module dmem_scrubber
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter bit SCRUB_EN   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  output logic                  o_scrub_we,
  output logic [DEPTH_LOG2-1:0] o_scrub_addr,
  output logic                  o_ready,
  output logic                  o_run
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = {DEPTH_LOG2{1'b1}};

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_scrub_ptr;
  logic                  r_ready;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= SCRUB_EN ? SCRUB : RUN;
      r_scrub_ptr <= '0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        SCRUB: begin
          r_scrub_ptr <= r_scrub_ptr + 1'b1;
          if (r_scrub_ptr == LAST_IDX) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= SCRUB;
        end
      endcase
    end
  end

  // Held off during reset so a reset cycle never writes the array.
  assign o_scrub_we   = RSTn && (r_state == SCRUB);
  assign o_scrub_addr = r_scrub_ptr;
  assign o_ready      = r_ready;
  assign o_run        = (r_state == RUN);

endmodule

// File: rtl/riscv_dmem_responder.sv
// Slave end of the core's D-memory port: byte-lane RAM with combinational read,
// post-reset zero scrub, sticky out-of-range flag and access counters.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter bit SCRUB_EN   = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CSN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DI,
  input  logic              WEN,
  input  logic [LANES-1:0]  BE,
  output logic [DATA_W-1:0] DOUT,
  output logic              READY,
  output logic              ERR,
  output logic [31:0]       RD_CNT,
  output logic [31:0]       WR_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  w_scrub_we;
  logic [DEPTH_LOG2-1:0] w_scrub_addr;
  logic                  w_run;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_acc;
  logic                  w_core_wr;
  logic                  w_core_rd;
  logic                  w_mem_wr;
  logic [DEPTH_LOG2-1:0] w_waddr;
  logic [DATA_W-1:0]     w_rd_word;

  logic                  r_err;
  logic [31:0]           r_rd_cnt;
  logic [31:0]           r_wr_cnt;

  dmem_scrubber #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .SCRUB_EN   (SCRUB_EN)
  ) u_scrubber (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .o_scrub_we   (w_scrub_we),
    .o_scrub_addr (w_scrub_addr),
    .o_ready      (READY),
    .o_run        (w_run)
  );

  assign w_in_range = ((ADDR >> DEPTH_LOG2) == '0);
  assign w_idx      = ADDR[DEPTH_LOG2-1:0];

  // Core traffic only counts once the scrub has handed over and reset is released.
  assign w_acc     = RSTn && w_run && (CSN == CSN_SEL);
  assign w_core_wr = w_acc && (WEN == WEN_WRITE);
  assign w_core_rd = w_acc && (WEN != WEN_WRITE);
  assign w_mem_wr  = w_core_wr && w_in_range;
  assign w_waddr   = w_scrub_we ? w_scrub_addr : w_idx;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BYTE_W-1:0] r_lane [0:DEPTH-1];
      logic              w_lane_we;
      logic [BYTE_W-1:0] w_lane_wd;

      assign w_lane_we = w_scrub_we || (w_mem_wr && BE[gi]);
      assign w_lane_wd = w_scrub_we ? '0 : DI[gi*BYTE_W +: BYTE_W];

      always_ff @(posedge CLK) begin
        if (w_lane_we) begin
          r_lane[w_waddr] <= w_lane_wd;
        end
      end

      assign w_rd_word[gi*BYTE_W +: BYTE_W] = r_lane[w_idx];
    end
  endgenerate

  assign DOUT = (w_core_rd && w_in_range) ? w_rd_word : '0;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_err    <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_acc && !w_in_range) begin
        r_err <= 1'b1;
      end
      if (w_core_rd) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (w_core_wr) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  assign ERR    = r_err;
  assign RD_CNT = r_rd_cnt;
  assign WR_CNT = r_wr_cnt;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder at DEPTH_LOG2=4: a vector table for
// byte-lane traffic plus hand-written scrub, reset and out-of-range sequences.
module tb_riscv_dmem_responder;

  logic        clk;
  logic        rstn;
  logic        csn;
  logic [11:0] addr;
  logic [31:0] di;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] dout;
  logic        ready;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  riscv_dmem_responder #(
    .DEPTH_LOG2 (4),
    .SCRUB_EN   (1'b1)
  ) dut (
    .CLK    (clk),
    .RSTn   (rstn),
    .CSN    (csn),
    .ADDR   (addr),
    .DI     (di),
    .WEN    (wen),
    .BE     (be),
    .DOUT   (dout),
    .READY  (ready),
    .ERR    (err),
    .RD_CNT (rd_cnt),
    .WR_CNT (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        csn;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] di;
    logic [3:0]  be;
    logic [31:0] exp_dout;
    logic [31:0] exp_wr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csn  = 1'b1;
    wen  = 1'b1;
    addr = '0;
    di   = '0;
    be   = '0;
  endtask

  task automatic reset_pulse();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Counts edges until READY is seen; returns 65 if it never rises.
  task automatic wait_ready(output int n);
    n = 65;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (ready === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic write_word(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    csn = 1'b0; wen = 1'b0; addr = a; di = d; be = b;
    tick();
    $display("write addr=0x%03h di=0x%08h be=%b", a, d, b);
    idle();
  endtask

  task automatic read_check(input logic [11:0] a, input logic [31:0] exp, input string name);
    csn = 1'b0; wen = 1'b1; addr = a; be = 4'b0000;
    #1;
    $display("read  addr=0x%03h dout=0x%08h", a, dout);
    check(name, dout, exp);
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    vecs[0]  = '{1'b0, 1'b0, 12'h005, 32'h11223344, 4'b1111, 32'h00000000, 32'd1, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 12'h005, 32'hAABBCCDD, 4'b0101, 32'h00000000, 32'd2, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 12'h005, 32'h00000000, 4'b1111, 32'h11BB33DD, 32'd2, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 12'h006, 32'hCAFEF00D, 4'b0000, 32'h00000000, 32'd3, 32'd1};
    vecs[4]  = '{1'b0, 1'b1, 12'h006, 32'h00000000, 4'b1111, 32'h00000000, 32'd3, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 12'h007, 32'h12345678, 4'b1000, 32'h00000000, 32'd4, 32'd2};
    vecs[6]  = '{1'b0, 1'b1, 12'h007, 32'h00000000, 4'b0001, 32'h12000000, 32'd4, 32'd3};
    vecs[7]  = '{1'b0, 1'b1, 12'h005, 32'h00000000, 4'b0000, 32'h11BB33DD, 32'd4, 32'd4};
    vecs[8]  = '{1'b1, 1'b1, 12'h005, 32'h00000000, 4'b1111, 32'h00000000, 32'd4, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 12'h007, 32'hFFFFFFFF, 4'b0010, 32'h00000000, 32'd5, 32'd4};
    vecs[10] = '{1'b0, 1'b1, 12'h007, 32'h00000000, 4'b0000, 32'h1200FF00, 32'd5, 32'd5};

    // Initial reset and reset-state outputs
    idle();
    rstn = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);
    rstn = 1'b1;
    wait_ready(n);
    check("init_ready_latency", n, 32'd16);

    // Scrub clears data written before a reset pulse
    write_word(12'h003, 32'hDEADBEEF, 4'b1111);
    read_check(12'h003, 32'hDEADBEEF, "preload_read");
    reset_pulse();
    wait_ready(n);
    check("scrub_ready_latency", n, 32'd16);
    read_check(12'h003, 32'h00000000, "scrubbed_read");
    check("scrub_rd_cnt", rd_cnt, 32'd1);

    // Byte-lane vector table from a clean state
    reset_pulse();
    wait_ready(n);
    check("table_ready_latency", n, 32'd16);
    for (int i = 0; i < 11; i++) begin
      csn = vecs[i].csn; wen = vecs[i].wen; addr = vecs[i].addr;
      di  = vecs[i].di;  be  = vecs[i].be;
      #1;
      $display("vec %0d csn=%b wen=%b addr=0x%03h di=0x%08h be=%b dout=0x%08h",
               i, csn, wen, addr, di, be, dout);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      tick();
      check($sformatf("vec%0d_wr_cnt", i), wr_cnt, vecs[i].exp_wr);
      check($sformatf("vec%0d_rd_cnt", i), rd_cnt, vecs[i].exp_rd);
    end
    idle();
    check("table_err", {31'b0, err}, 32'h0);

    // Core accesses during SCRUB are ignored
    reset_pulse();
    tick(); tick(); tick();
    csn = 1'b0; wen = 1'b0; addr = 12'h002; di = 32'hFFFFFFFF; be = 4'b1111;
    tick();
    addr = 12'h000;
    tick();
    wen = 1'b1; addr = 12'h001;
    #1;
    check("scrub_read_dout", dout, 32'h0);
    tick();
    idle();
    wait_ready(n);
    check("scrub_block_ready", n, 32'd10);
    check("scrub_block_wr_cnt", wr_cnt, 32'd0);
    check("scrub_block_rd_cnt", rd_cnt, 32'd0);
    check("scrub_block_err", {31'b0, err}, 32'h0);
    read_check(12'h002, 32'h00000000, "scrub_block_addr2");
    read_check(12'h000, 32'h00000000, "scrub_block_addr0");

    // Out-of-range accesses
    write_word(12'h000, 32'h0BADF00D, 4'b1111);
    check("oor_err_before", {31'b0, err}, 32'h0);
    write_word(12'h010, 32'hFFFFFFFF, 4'b1111);
    check("oor_err_after_write", {31'b0, err}, 32'h1);
    read_check(12'h000, 32'h0BADF00D, "oor_mem0_kept");
    read_check(12'h7FF, 32'h00000000, "oor_read_dout");
    check("oor_err_sticky", {31'b0, err}, 32'h1);
    check("oor_wr_cnt", wr_cnt, 32'd2);
    check("oor_rd_cnt", rd_cnt, 32'd4);
    rstn = 1'b0;
    tick();
    check("oor_err_cleared", {31'b0, err}, 32'h0);

    // Reset in the middle of scrubbing restarts the sweep
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    check("midscrub_ready_low", {31'b0, ready}, 32'h0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wait_ready(n);
    check("midscrub_ready_latency", n, 32'd16);
    check("midscrub_wr_cnt", wr_cnt, 32'd0);
    check("midscrub_rd_cnt", rd_cnt, 32'd0);

    // Deselected write attempts have no effect
    for (int k = 0; k < 5; k++) begin
      csn = 1'b1; wen = 1'b0; addr = 12'h001; di = 32'hFFFFFFFF; be = 4'b1111;
      #1;
      check($sformatf("desel%0d_dout", k), dout, 32'h0);
      tick();
    end
    idle();
    check("desel_wr_cnt", wr_cnt, 32'd0);
    check("desel_rd_cnt", rd_cnt, 32'd0);
    read_check(12'h001, 32'h00000000, "desel_mem1");
    check("desel_err", {31'b0, err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder for the pipelined RISC-V core: the slave end of the core's D-memory interface (chip select, word address, write data, write enable, byte enables, read data). It holds a word-addressed RAM with byte-lane writes and combinational reads, scrubs the whole array to zero after reset, and flags out-of-range accesses. It also keeps read/write access counters for the test harness.

## Interface
- DEPTH_LOG2, 10: log2 of the word count. The array is 2^DEPTH_LOG2 words of 32 bits.
- SCRUB_EN, 1: 1 = zero the whole array after reset; 0 = skip scrubbing (contents undefined).
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- CSN  in  1  chip select, active-low.
- ADDR  in  12  word address.
- DI  in  32  write data from the core.
- WEN  in  1  write enable, active-low. 0 = write, 1 = read.
- BE  in  4  byte enables; BE[i] gates DI[8i+7:8i].
- DOUT  out  32  read data to the core.
- READY  out  1  1 once scrubbing is complete.
- ERR  out  1  sticky out-of-range access flag.
- RD_CNT  out  32  number of accepted reads.
- WR_CNT  out  32  number of accepted writes.

## Operation
- State machine with two states, SCRUB and RUN.
- RSTn=0 at an edge:
  - state←SCRUB, or RUN if SCRUB_EN=0;
  - scrub_ptr←0, ERR←0, RD_CNT←0, WR_CNT←0.
  - Array contents are not touched by reset itself.
- SCRUB: each cycle writes 0 to mem[scrub_ptr] and increments scrub_ptr. On the edge that writes index 2^DEPTH_LOG2−1, state←RUN.
- Core accesses in SCRUB are ignored: no write, DOUT=0, no count, no ERR.
- Accepted access: state=RUN and CSN=0.
- In range means ADDR[11:DEPTH_LOG2]==0. The index is ADDR[DEPTH_LOG2-1:0].
- Accepted write (WEN=0), in range:
  - each byte lane with BE[i]=1 is updated at the edge; other lanes are kept;
  - WR_CNT+1, including when BE=0000.
- Accepted read (WEN=1), in range: DOUT=mem[index] combinationally, with the full word regardless of BE; RD_CNT+1.
- Accepted access out of range:
  - write is dropped; read returns DOUT=0;
  - ERR←1, which holds until reset;
  - the matching counter still increments.
- DOUT=0 whenever CSN=1, WEN=0, state=SCRUB, or the address is out of range.
- Counters wrap modulo 2^32.

## Timing
- Read latency 0: DOUT follows ADDR in the same cycle. The core samples it at the next edge.
- Write commits at the rising edge where CSN=0, WEN=0, RUN.
- Read-after-write to the same address:
  - the same cycle is impossible, since there is one port;
  - the next cycle returns the new data.
- READY is registered: it rises the cycle after the final scrub write, 2^DEPTH_LOG2 cycles after RSTn deasserts. With SCRUB_EN=0 it rises 1 cycle after RSTn deasserts.
- ERR and the counters update at the access edge and are visible in the next cycle.
- Reset outputs: DOUT=0, READY=0, ERR=0, RD_CNT=0, WR_CNT=0.
- Reset during SCRUB restarts at scrub_ptr=0. Reset during RUN re-enters SCRUB; array data is kept until scrubbed.

## Structure
- Shared package holds:
  - state enum {SCRUB, RUN};
  - lane constants: BYTE_W=8, LANES=4;
  - the WEN_WRITE=0 and CSN_SEL=0 polarity constants.
- Sub-module dmem_scrubber: owns scrub_ptr and the SCRUB→RUN transition, and outputs scrub_we, scrub_addr and READY. The top muxes the array write port between the scrubber and the core.
- The byte-lane merge stays in the top as a per-lane generate loop.

## Test plan
All scenarios use DEPTH_LOG2=4.
- Scrub: preload mem[3]=0xDEADBEEF, pulse RSTn=0 for 1 cycle.
  - Expect READY=0 for 16 cycles, then 1.
  - Read ADDR=3 → DOUT=0x00000000, RD_CNT=1.
- Byte lanes: write 0x11223344 with BE=1111 to ADDR=5, then 0xAABBCCDD with BE=0101.
  - Read ADDR=5 → 0x11BB33DD; WR_CNT=2.
- SCRUB blocking: write ADDR=2 with WEN=0 at cycle 3 after reset (during SCRUB).
  - After READY, read ADDR=2 → 0, WR_CNT=0, ERR=0.
- Out of range: write ADDR=0x010.
  - Expect mem[0] unchanged and ERR=1 on the next cycle.
  - Read ADDR=0x7FF → DOUT=0; ERR stays 1 until RSTn=0.
- Reset mid-scrub: assert RSTn=0 at scrub cycle 9.
  - READY rises exactly 16 cycles after the second release; counters stay 0.
- Deselect: CSN=1, WEN=0, BE=1111, ADDR=1, DI=0xFFFFFFFF for 5 cycles.
  - mem[1] stays 0, DOUT=0, counters unchanged.
